// File: rtl/panic_class_scheduler.sv
// panic_class_scheduler
// Packet-granular weighted round-robin arbiter. It merges N_CLASS per-class
// AXI streams into one stream toward the DMA. Each class has a per-epoch beat
// budget. A class that has used up its budget is throttled until the next
// epoch boundary. In work-conserving mode a throttled class may still send
// when no in-budget class has data.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   s_axis_*             N_CLASS input streams, class i in slice i
//   m_axis_*             merged output stream, zero-latency pass-through
//   m_flow_class         class index of the beat on m_axis
//   cfg_credit           per-class beat budget per epoch (0 = unlimited)
//   cfg_work_conserving  serve throttled classes when nothing in-budget is valid
//   epoch_tick           one-cycle pulse on the last cycle of each epoch
//   class_throttled      registered per-class "usage >= budget" flag
//   dbg_state            FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// tready never depends on tvalid of the same stream. Sources must hold
// tvalid and the payload stable until the beat transfers.
module panic_class_scheduler #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int N_CLASS         = 5,
    parameter int CLASS_WIDTH     = 5,
    parameter int CREDIT_WIDTH    = 16,
    parameter int EPOCH_LOG       = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_CLASS*AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [N_CLASS*AXIS_KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [N_CLASS-1:0]                  s_axis_tvalid,
    output logic [N_CLASS-1:0]                  s_axis_tready,
    input  logic [N_CLASS-1:0]                  s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [CLASS_WIDTH-1:0]              m_flow_class,
    input  logic [N_CLASS*CREDIT_WIDTH-1:0]     cfg_credit,
    input  logic                                cfg_work_conserving,
    output logic                                epoch_tick,
    output logic [N_CLASS-1:0]                  class_throttled,
    output logic                                dbg_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CLASS_WIDTH-1:0]   grant_q, grant_d;
    logic [CLASS_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CREDIT_WIDTH-1:0]  usage_q [N_CLASS];
    logic [CREDIT_WIDTH-1:0]  usage_d [N_CLASS];
    logic [EPOCH_LOG-1:0]     epoch_q, epoch_d;
    logic [N_CLASS-1:0]       throttled_q, throttled_d;

    logic [N_CLASS-1:0]       eligible;
    logic [N_CLASS-1:0]       pool;
    logic                     cand_found;
    logic [CLASS_WIDTH-1:0]   cand_idx;
    logic                     beat_fire;

    // Candidate selection: in-budget classes first; in work-conserving mode
    // fall back to every valid class. Scan starts one past the last winner.
    always_comb begin
        eligible   = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            eligible[i] = s_axis_tvalid[i] &&
                ((cfg_credit[i*CREDIT_WIDTH +: CREDIT_WIDTH] == '0) ||
                 (usage_q[i] < cfg_credit[i*CREDIT_WIDTH +: CREDIT_WIDTH]));
        end
        if (eligible != '0) begin
            pool = eligible;
        end else if (cfg_work_conserving) begin
            pool = s_axis_tvalid;
        end else begin
            pool = '0;
        end
        for (int k = 0; k < N_CLASS; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + 1 + k;
            if (idx >= N_CLASS) idx = idx - N_CLASS;
            if (!cand_found && pool[idx]) begin
                cand_found = 1'b1;
                cand_idx   = CLASS_WIDTH'(idx);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= CLASS_WIDTH'(N_CLASS - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state. The grant is held until the tlast beat transfers,
    // even if the budget runs out mid-packet.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (cand_found) begin
                    grant_d  = cand_idx;
                    rr_ptr_d = cand_idx;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (beat_fire && m_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Pure combinational pass-through of the granted class.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_flow_class  = '0;
        s_axis_tready = '0;
        if (state_q == BUSY) begin
            m_flow_class = grant_q;
            for (int i = 0; i < N_CLASS; i++) begin
                if (grant_q == CLASS_WIDTH'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                    m_axis_tkeep     = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign beat_fire  = m_axis_tvalid && m_axis_tready;
    assign epoch_tick = &epoch_q;
    assign dbg_state  = (state_q == BUSY);

    // Usage and epoch bookkeeping. On the epoch boundary every counter
    // restarts; a beat in that same cycle counts toward the new epoch.
    always_comb begin
        epoch_d     = epoch_q + EPOCH_LOG'(1);
        throttled_d = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            logic beat_i;
            beat_i = beat_fire && (grant_q == CLASS_WIDTH'(i));
            usage_d[i] = usage_q[i];
            if (epoch_tick) begin
                usage_d[i] = beat_i ? CREDIT_WIDTH'(1) : '0;
            end else if (beat_i && (usage_q[i] != '1)) begin
                usage_d[i] = usage_q[i] + CREDIT_WIDTH'(1);
            end
            throttled_d[i] = (cfg_credit[i*CREDIT_WIDTH +: CREDIT_WIDTH] != '0) &&
                             (usage_d[i] >= cfg_credit[i*CREDIT_WIDTH +: CREDIT_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epoch_q     <= '0;
            throttled_q <= '0;
            for (int i = 0; i < N_CLASS; i++) usage_q[i] <= '0;
        end else begin
            epoch_q     <= epoch_d;
            throttled_q <= throttled_d;
            for (int i = 0; i < N_CLASS; i++) usage_q[i] <= usage_d[i];
        end
    end

    assign class_throttled = throttled_q;

endmodule

// File: tb/tb_panic_class_scheduler.sv
// Directed bench for panic_class_scheduler. Source queues feed the per-class
// streams. Expected beats are queued in hand-computed grant order, and a
// monitor compares every beat that leaves m_axis.
module tb_panic_class_scheduler;
    localparam int DW    = 256;
    localparam int KW    = DW / 8;
    localparam int NC    = 5;
    localparam int CW    = 5;
    localparam int CRW   = 16;
    localparam int EXP_W = 8 + 1 + KW + 32;

    typedef struct packed {
        logic [7:0]    cls;
        logic [31:0]   tag;
        logic          last;
        logic [KW-1:0] keep;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*DW-1:0]  s_axis_tdata;
    logic [NC*KW-1:0]  s_axis_tkeep;
    logic [NC-1:0]     s_axis_tvalid;
    logic [NC-1:0]     s_axis_tready;
    logic [NC-1:0]     s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [CW-1:0]     m_flow_class;
    logic [NC*CRW-1:0] cfg_credit;
    logic              cfg_work_conserving;
    logic              epoch_tick;
    logic [NC-1:0]     class_throttled;
    logic              dbg_state;

    beat_t             src_q[$];
    logic [EXP_W-1:0]  exp_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                next_id = 0;
    int                cyc = 0;
    int                first_cyc = -1;
    int                last_cyc = -1;

    always #5 clk = ~clk;

    panic_class_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tlast        (s_axis_tlast),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tkeep        (m_axis_tkeep),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tlast        (m_axis_tlast),
        .m_flow_class        (m_flow_class),
        .cfg_credit          (cfg_credit),
        .cfg_work_conserving (cfg_work_conserving),
        .epoch_tick          (epoch_tick),
        .class_throttled     (class_throttled),
        .dbg_state           (dbg_state)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int cls, input int id, input int b, input int len);
        beat_t r;
        r.cls  = 8'(cls);
        r.tag  = {8'(cls), 8'(id), 16'(b)};
        r.last = (b == len - 1);
        r.keep = r.last ? KW'(32'h0000_ffff) : '1;
        return r;
    endfunction

    task automatic load_pkt(input int cls, input int len, output int id);
        id = next_id;
        next_id++;
        for (int b = 0; b < len; b++) src_q.push_back(mk_beat(cls, id, b, len));
    endtask

    task automatic expect_pkt(input int cls, input int id, input int len);
        beat_t e;
        for (int b = 0; b < len; b++) begin
            e = mk_beat(cls, id, b, len);
            exp_q.push_back({e.cls, e.last, e.keep, e.tag});
        end
    endtask

    task automatic set_credit(input int cls, input int val);
        cfg_credit[cls*CRW +: CRW] = CRW'(val);
    endtask

    // Source driver: handshakes are sampled mid-cycle, accepted beats are
    // removed after the edge and the next head of each class is presented.
    initial begin
        logic [NC-1:0] hs;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #2;
            for (int c = 0; c < NC; c++) begin
                if (hs[c]) begin
                    for (int i = 0; i < src_q.size(); i++) begin
                        if (src_q[i].cls == 8'(c)) begin
                            src_q.delete(i);
                            break;
                        end
                    end
                end
            end
            s_axis_tvalid = '0;
            s_axis_tlast  = '0;
            for (int c = 0; c < NC; c++) begin
                for (int i = 0; i < src_q.size(); i++) begin
                    if (src_q[i].cls == 8'(c)) begin
                        s_axis_tvalid[c]          = 1'b1;
                        s_axis_tdata[c*DW +: DW]  = DW'(src_q[i].tag);
                        s_axis_tkeep[c*KW +: KW]  = src_q[i].keep;
                        s_axis_tlast[c]           = src_q[i].last;
                        break;
                    end
                end
            end
        end
    end

    // Monitor: compares every beat leaving m_axis against the expected queue.
    initial begin
        logic [EXP_W-1:0] got;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst && m_axis_tvalid) check("valid_only_busy", dbg_state, 1'b1);
            if (rst && m_axis_tvalid && m_axis_tready) begin
                got = {8'(m_flow_class), m_axis_tlast, m_axis_tkeep, m_axis_tdata[31:0]};
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                check("beat_hi_zero", m_axis_tdata[DW-1:32], '0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", got);
                end else begin
                    check("beat", got, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        cfg_credit = '0;
        cfg_work_conserving = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    task automatic wait_size(input string name, input int n, input int max);
        int i = 0;
        while (exp_q.size() != n && i < max) begin
            @(negedge clk);
            i++;
        end
        check(name, exp_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string name, input int max);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!epoch_tick && i < max);
        check(name, epoch_tick, 1'b1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int id;
        int a[4];
        int b[20];
        rst = 1'b0;
        m_axis_tready = 1'b1;
        cfg_credit = '0;
        cfg_work_conserving = 1'b0;
        #1;
        check("rst_m_valid", m_axis_tvalid, 1'b0);
        check("rst_outputs", {s_axis_tready, m_axis_tlast, m_flow_class, epoch_tick, class_throttled, dbg_state}, '0);

        // Round-robin over all classes, unlimited budget.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NC; c++) begin
                load_pkt(c, 4, id);
                expect_pkt(c, id, 4);
            end
        end
        wait_size("t1_drain", 0, 200);
        check("t1_span", last_cyc - first_cyc, 48);

        // Class 0 budget 8 against unlimited class 1, no work conserving.
        do_reset();
        set_credit(0, 8);
        for (int p = 0; p < 4; p++) load_pkt(0, 4, a[p]);
        for (int p = 0; p < 20; p++) load_pkt(1, 4, b[p]);
        expect_pkt(0, a[0], 4);
        expect_pkt(1, b[0], 4);
        expect_pkt(0, a[1], 4);
        for (int p = 1; p < 20; p++) expect_pkt(1, b[p], 4);
        expect_pkt(0, a[2], 4);
        expect_pkt(0, a[3], 4);
        wait_size("t2_budget_used", 8, 300);
        wait_cycles(10);
        check("t2_stalled", exp_q.size(), 8);
        check("t2_throttled", class_throttled[0], 1'b1);
        check("t2_no_valid", m_axis_tvalid, 1'b0);
        wait_tick("t2_tick", 1100);
        @(negedge clk);
        check("t2_unthrottled", class_throttled[0], 1'b0);
        wait_size("t2_drain", 0, 60);
        check("t2_rethrottled", class_throttled[0], 1'b1);

        // Work conserving: lone class 0 keeps sending past its budget.
        do_reset();
        set_credit(0, 8);
        cfg_work_conserving = 1'b1;
        for (int p = 0; p < 6; p++) begin
            load_pkt(0, 4, id);
            expect_pkt(0, id, 4);
        end
        wait_size("t3_drain", 0, 100);
        check("t3_span", last_cyc - first_cyc, 28);
        check("t3_throttled", class_throttled[0], 1'b1);

        // Budget 6: second packet starts at usage 4 and completes (usage 8).
        do_reset();
        set_credit(2, 6);
        for (int p = 0; p < 3; p++) begin
            load_pkt(2, 4, id);
            expect_pkt(2, id, 4);
        end
        wait_size("t4_two_pkts", 4, 60);
        wait_cycles(10);
        check("t4_stalled", exp_q.size(), 4);
        check("t4_throttled", class_throttled[2], 1'b1);
        set_credit(2, 8);
        wait_cycles(5);
        check("t4_usage_ge8", {exp_q.size() == 4, class_throttled[2]}, 2'b11);
        set_credit(2, 9);
        @(negedge clk);
        @(negedge clk);
        check("t4_usage_lt9", class_throttled[2], 1'b0);
        wait_size("t4_drain", 0, 40);
        check("t4_usage_ge9", class_throttled[2], 1'b1);

        // Beat in the epoch_tick cycle counts as usage 1 in the new epoch.
        do_reset();
        set_credit(1, 1);
        set_credit(3, 1);
        wait_cycles(990);
        load_pkt(1, 4, id);
        expect_pkt(1, id, 4);
        load_pkt(3, 60, id);
        expect_pkt(3, id, 60);
        wait_tick("t5_tick", 200);
        check("t5_tick_beat", {m_axis_tvalid, m_axis_tready, m_flow_class}, {1'b1, 1'b1, 5'd3});
        check("t5_pre_thr1", class_throttled[1], 1'b1);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("t5_post_thr", class_throttled, 5'b01000);
        @(posedge clk);
        #1;
        set_credit(3, 2);
        @(negedge clk);
        @(negedge clk);
        check("t5_usage_is1", class_throttled, 5'b00000);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_size("t5_drain", 0, 100);

        // Asynchronous reset in the middle of a stalled packet.
        do_reset();
        load_pkt(2, 4, id);
        expect_pkt(2, id, 4);
        wait_size("t6_first", 0, 20);
        m_axis_tready = 1'b0;
        load_pkt(3, 4, a[0]);
        load_pkt(0, 4, a[1]);
        load_pkt(4, 4, a[2]);
        expect_pkt(0, a[1], 4);
        expect_pkt(3, a[0], 4);
        expect_pkt(4, a[2], 4);
        begin
            int i = 0;
            do begin
                @(negedge clk);
                i++;
            end while (!m_axis_tvalid && i < 10);
        end
        check("t6_granted3", {m_axis_tvalid, m_flow_class}, {1'b1, 5'd3});
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_valid", m_axis_tvalid, 1'b0);
        check("t6_async_outs", {s_axis_tready, m_axis_tlast, m_flow_class, epoch_tick, class_throttled, dbg_state}, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_axis_tready = 1'b1;
        wait_size("t6_drain", 0, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/panic_class_scheduler.md
Name: panic_class_scheduler

Overview:
- Packet-granular weighted arbiter that merges N_CLASS per-flow-class AXI streams into one stream toward the DMA.
- Each class gets a per-epoch frame (beat) budget. Classes that exhaust their budget are throttled until the next epoch boundary.
- An optional work-conserving mode lets throttled classes use otherwise idle bandwidth.
- Sits upstream of the rx performance counters; its output drives the DMA-side stream those counters observe.

Parameters:
- AXIS_DATA_WIDTH, 256, data width per stream in bits
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
- N_CLASS, 5, number of flow-class input streams
- CLASS_WIDTH, 5, width of the class index output
- CREDIT_WIDTH, 16, width of per-class budget and usage counters
- EPOCH_LOG, 10, epoch length is 2^EPOCH_LOG cycles

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- s_axis_tdata  in  N_CLASS*AXIS_DATA_WIDTH  per-class data; class i occupies slice i
- s_axis_tkeep  in  N_CLASS*AXIS_KEEP_WIDTH  per-class keep
- s_axis_tvalid  in  N_CLASS  per-class valid
- s_axis_tready  out  N_CLASS  per-class ready
- s_axis_tlast  in  N_CLASS  per-class last
- m_axis_tdata  out  AXIS_DATA_WIDTH  merged data
- m_axis_tkeep  out  AXIS_KEEP_WIDTH  merged keep
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  merged last
- m_flow_class  out  CLASS_WIDTH  class index of the current beat
- cfg_credit  in  N_CLASS*CREDIT_WIDTH  frames allowed per class per epoch; 0 = unlimited
- cfg_work_conserving  in  1  1 = serve throttled classes when no in-budget class is valid
- epoch_tick  out  1  one-cycle pulse on the epoch-boundary cycle
- class_throttled  out  N_CLASS  per-class flag: usage >= budget and budget != 0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, rr_ptr=N_CLASS-1.
  - All usage counters 0, epoch counter 0.
  - All outputs 0 (s_axis_tready, m_axis_tvalid, m_axis_tlast, m_flow_class, epoch_tick, class_throttled).
- Reset asserted mid-packet: the packet is abandoned and no further beats of it are forwarded. Upstream is responsible for resynchronisation.
- Eligibility: class i is eligible when tvalid[i]=1 and (cfg_credit[i]==0 or usage[i] < cfg_credit[i]).
- Candidate selection:
  - Round-robin over eligible classes, starting at rr_ptr+1 mod N_CLASS.
  - If no class is eligible and cfg_work_conserving=1, round-robin over all classes with tvalid=1, same start point.
  - Otherwise there is no candidate.
- FSM, states IDLE and BUSY:
  - IDLE: if a candidate exists, register grant=candidate and rr_ptr=candidate, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: combinational pass-through of class grant. m_axis_* = slice grant, m_flow_class = grant, s_axis_tready[grant] = m_axis_tready, all other readies 0.
  - BUSY exit: on the handshake of the beat with tlast=1, return to IDLE.
- Timing:
  - Zero datapath latency.
  - Exactly one idle bubble cycle between consecutive packets.
  - A grant is held for the whole packet regardless of budget exhaustion mid-packet; packets are never truncated.
- Usage counting:
  - Each handshaked beat of class g increments usage[g].
  - Usage saturates at 2^CREDIT_WIDTH-1.
  - class_throttled is registered from the updated usage (valid one cycle after the beat).
- Epoch:
  - The epoch counter (EPOCH_LOG bits) increments every cycle and wraps.
  - epoch_tick=1 in the cycle the counter equals all-ones.
  - In that cycle all usage counters load 0. A beat transferring in the same cycle makes its class's usage load 1 instead of 0.
- cfg_credit changes: take effect on the next eligibility evaluation. Lowering a budget below current usage throttles the class immediately; usage is not cleared.
- m_axis_tvalid is never asserted in IDLE.
- tvalid on a non-granted class with tready=0 must be held stable by the source (AXI rule). The block neither drops nor reorders beats within a class.

Test Plan:
- Reset, then all 5 classes continuously valid with 4-beat packets, cfg_credit=0 -> packet grant order 0,1,2,3,4,0,...; each packet is 4 beats plus 1 bubble; m_flow_class matches the source.
- cfg_credit[0]=8, cfg_credit[1]=0, both saturated with 4-beat packets, work-conserving off -> class 0 sends exactly 8 beats per 1024-cycle epoch, then class_throttled[0]=1 until epoch_tick; class 1 takes the remainder.
- Same setup as above but only class 0 valid, work-conserving on -> class 0 continues after its budget (about 819 beats per epoch); class_throttled[0] stays 1.
- Class 2 budget 6 with 4-beat packets -> second packet is granted at usage 4 and completes fully; usage reaches 8; no third packet until the epoch wraps.
- Beat handshaked in the epoch_tick cycle -> that class's usage reads 1 in the next cycle; all other classes read 0.
- Assert rst mid-packet with m_axis_tready=0 -> outputs go to 0 immediately (asynchronous); after release the FSM is in IDLE and the next grant is class 0.
